parity_checker: RTL and testbench
=================================

Name: parity_checker

Overview:
- Serial frame receiver that checks parity for the team's serial parity path. It is the receive-side counterpart of the running-parity generator.
- Accepts a framed bit stream, one bit per bit_en strobe: start bit, DATA_W data bits (LSB first), parity bit, stop bit.
- Reassembles the data word and flags parity and framing errors.
- Sits at the link input, ahead of the consumer logic.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 1..32).
- ODD_PARITY, 0, 0 = even parity (data ones + parity bit is even); 1 = odd parity (that total is odd).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; x is sampled only on cycles with bit_en = 1.
- x  input  1  serial line; idles at 1.
- dout  output  DATA_W  received data word; holds the last frame until the next frame completes.
- dout_valid  output  1  one-cycle pulse when a frame completes with no error.
- parity_err  output  1  one-cycle pulse at frame completion if parity mismatched.
- frame_err  output  1  one-cycle pulse at frame completion if the stop bit sampled 0.
- busy  output  1  high from start-bit acceptance until frame completion.
- run_par  output  1  running XOR of the data bits received so far in the current frame; cleared at start bit.

Behaviour:
- Reset (rst = 1 at posedge): state = IDLE; dout = 0; dout_valid = parity_err = frame_err = busy = run_par = 0; bit counter = 0. Reset mid-frame abandons the frame; no error pulse is issued.
- State machine. Every transition happens only on a cycle with bit_en = 1; with bit_en = 0 the state, counter and shift register hold.
  - IDLE: x = 0 -> DATA, busy <= 1, run_par <= 0, count <= 0. x = 1 -> stay in IDLE.
  - DATA: shift x into shift_reg[count] (LSB first), run_par <= run_par ^ x, count <= count + 1. When count = DATA_W-1 -> PARITY.
  - PARITY: capture par_bit <= x -> STOP.
  - STOP: frame completes.
    - dout <= shift_reg.
    - perr = run_par ^ par_bit ^ ODD_PARITY.
    - ferr = ~x.
    - parity_err <= perr, frame_err <= ferr, dout_valid <= ~perr & ~ferr.
    - busy <= 0 -> IDLE.
- dout is updated on every completed frame, including errored ones. The error flags qualify it.
- Pulses: dout_valid, parity_err and frame_err are high exactly one clk cycle, the cycle after the STOP sample. They are deasserted on the next clk regardless of bit_en. parity_err and frame_err may assert together.
- Latency: dout_valid rises 1 clk after the bit_en cycle that samples the stop bit.
- Frame length is DATA_W + 3 bit_en strobes.
- Back-to-back frames: a start bit may be accepted on the first bit_en after STOP. No idle bit is required.
- A stop bit of 0 is not treated as a new start bit. The checker returns to IDLE and waits for the next bit_en with x = 0.
- There is no start-bit glitch rejection; one bit_en sample of 0 in IDLE starts a frame.
- count width = clog2(DATA_W) + 1; it must not wrap inside a frame.

Test Plan:
- Reset, then DATA_W = 8, even parity, bit_en every cycle, frame 0, 0xA5 LSB first, parity 0, stop 1 -> dout = 0xA5, dout_valid pulse 1 cycle after stop, parity_err = frame_err = 0. run_par = 0 at frame end.
- Same frame with parity bit 1 -> dout = 0xA5, parity_err = 1 for one cycle, dout_valid = 0. Repeat with ODD_PARITY = 1: parity bit 1 valid, parity bit 0 errors.
- Frame 0x3C, correct parity, stop bit 0 -> frame_err = 1, dout_valid = 0, dout = 0x3C. Checker returns to IDLE; a following x = 1 does not start a frame.
- bit_en asserted every 4th cycle, x changing on non-strobe cycles, frame 0x81 -> dout = 0x81 valid. Non-strobe values are ignored and busy stays high across the frame.
- Two back-to-back frames 0x01 then 0xFE with no idle bit -> two dout_valid pulses, DATA_W + 3 strobes apart, with dout = 0x01 then 0xFE.
- Assert rst after 4 data bits -> busy = 0 and no pulses. The next full frame 0x55 is received correctly.

Source files
------------

// File: rtl/parity_checker.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop; flags parity/framing errors.
// Result pulses one clk after the stop-bit strobe; bit_en=0 freezes the receiver, no backpressure.
module parity_checker #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              x,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic              run_par
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
    localparam logic ODD = (ODD_PARITY != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt, dout_nxt;
    logic              par_bit, par_nxt;
    logic              busy_nxt, run_nxt;
    logic              valid_nxt, perr_nxt, ferr_nxt;
    logic              perr, ferr;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        shift_nxt = shift_reg;
        dout_nxt  = dout;
        par_nxt   = par_bit;
        busy_nxt  = busy;
        run_nxt   = run_par;
        valid_nxt = 1'b0;
        perr_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        perr      = run_par ^ par_bit ^ ODD;
        ferr      = ~x;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!x) begin
                        state_nxt = DATA;
                        busy_nxt  = 1'b1;
                        run_nxt   = 1'b0;
                        count_nxt = '0;
                    end
                end
                DATA: begin
                    // Right shift: after DATA_W bits the first (LSB) bit sits at position 0.
                    shift_nxt              = shift_reg >> 1;
                    shift_nxt[DATA_W-1]    = x;
                    run_nxt                = run_par ^ x;
                    count_nxt              = count + CW'(1);
                    if (count == LAST) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    par_nxt   = x;
                    state_nxt = STOP;
                end
                STOP: begin
                    dout_nxt  = shift_reg;
                    perr_nxt  = perr;
                    ferr_nxt  = ferr;
                    valid_nxt = ~perr & ~ferr;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            shift_reg  <= '0;
            dout       <= '0;
            par_bit    <= 1'b0;
            busy       <= 1'b0;
            run_par    <= 1'b0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            shift_reg  <= shift_nxt;
            dout       <= dout_nxt;
            par_bit    <= par_nxt;
            busy       <= busy_nxt;
            run_par    <= run_nxt;
            dout_valid <= valid_nxt;
            parity_err <= perr_nxt;
            frame_err  <= ferr_nxt;
        end
    end

endmodule

// File: tb/tb_parity_checker.sv
// Drives even- and odd-parity receivers with directed and random frames; expectations come from frame-level rules.
module tb_parity_checker;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          bit_en;
    logic          x;
    logic [DW-1:0] dout_e, dout_o;
    logic          valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o;
    logic          busy_e, busy_o, rp_e, rp_o;

    int total = 0;
    int bad   = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    parity_checker #(.DATA_W(DW), .ODD_PARITY(0)) u_even (
        .clk(clk), .rst(rst), .bit_en(bit_en), .x(x),
        .dout(dout_e), .dout_valid(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e), .run_par(rp_e)
    );

    parity_checker #(.DATA_W(DW), .ODD_PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en), .x(x),
        .dout(dout_o), .dout_valid(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o), .run_par(rp_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid_e"}, 32'(valid_e), 0);
        chk({tag, "_valid_o"}, 32'(valid_o), 0);
        chk({tag, "_perr_e"},  32'(perr_e), 0);
        chk({tag, "_perr_o"},  32'(perr_o), 0);
        chk({tag, "_ferr_e"},  32'(ferr_e), 0);
        chk({tag, "_ferr_o"},  32'(ferr_o), 0);
    endtask

    // Idle cycles before the strobe carry random x that must be ignored.
    task automatic strobe(input logic b, input int gap, input logic hold_busy);
        for (int k = 1; k < gap; k++) begin
            bit_en = 1'b0;
            x      = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_busy_e", 32'(busy_e), 32'(hold_busy));
            chk("hold_busy_o", 32'(busy_o), 32'(hold_busy));
        end
        bit_en = 1'b1;
        x      = b;
        @(posedge clk); #1;
        bit_en = 1'b0;
        x      = 1'b1;
        strobes++;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pb, input logic sb,
                              input int gap, output int stop_at);
        logic rp;
        logic pe_e, pe_o, fe;
        strobe(1'b0, gap, busy_e);
        chk("start_busy", 32'({busy_e, busy_o}), 32'h3);
        chk("start_rp", 32'({rp_e, rp_o}), 0);
        chk_quiet("start");
        rp = 1'b0;
        for (int i = 0; i < DW; i++) begin
            strobe(d[i], gap, 1'b1);
            rp ^= d[i];
            chk("data_rp_e", 32'(rp_e), 32'(rp));
            chk("data_rp_o", 32'(rp_o), 32'(rp));
            chk("data_busy", 32'({busy_e, busy_o}), 32'h3);
        end
        strobe(pb, gap, 1'b1);
        strobe(sb, gap, 1'b1);
        stop_at = strobes;
        pe_e = (rp ^ pb) != 1'b0;
        pe_o = (rp ^ pb) != 1'b1;
        fe   = ~sb;
        chk("dout_e", 32'(dout_e), 32'(d));
        chk("dout_o", 32'(dout_o), 32'(d));
        chk("perr_e", 32'(perr_e), 32'(pe_e));
        chk("perr_o", 32'(perr_o), 32'(pe_o));
        chk("ferr_e", 32'(ferr_e), 32'(fe));
        chk("ferr_o", 32'(ferr_o), 32'(fe));
        chk("valid_e", 32'(valid_e), 32'(!pe_e && !fe));
        chk("valid_o", 32'(valid_o), 32'(!pe_o && !fe));
        chk("end_busy", 32'({busy_e, busy_o}), 0);
        chk("end_rp", 32'({rp_e, rp_o}), 32'({rp, rp}));
    endtask

    initial begin
        int s1, s2;
        logic [DW-1:0] d;

        rst = 1'b1; bit_en = 1'b0; x = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'({dout_e, dout_o}), 0);
        chk("rst_busy", 32'({busy_e, busy_o}), 0);
        chk("rst_rp", 32'({rp_e, rp_o}), 0);
        chk_quiet("rst");
        rst = 1'b0;

        // 0xA5 with both parity-bit values: valid on one DUT, parity error on the other.
        send_frame(8'hA5, 1'b0, 1'b1, 1, s1);
        @(posedge clk); #1;
        chk_quiet("a5_drop");
        send_frame(8'hA5, 1'b1, 1'b1, 1, s1);
        @(posedge clk); #1;
        chk_quiet("a5p_drop");

        // Framing error, then idle-level strobes must not start a frame.
        send_frame(8'h3C, 1'b0, 1'b0, 1, s1);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1, 1'b0);
            chk("ferr_idle_busy", 32'({busy_e, busy_o}), 0);
            chk("ferr_idle_dout", 32'(dout_e), 32'h3C);
            chk_quiet("ferr_idle");
        end

        // Sparse strobes every 4th cycle.
        send_frame(8'h81, 1'b0, 1'b1, 4, s1);

        // Back-to-back frames with no idle bit.
        send_frame(8'h01, 1'b1, 1'b1, 1, s1);
        send_frame(8'hFE, 1'b1, 1'b1, 1, s2);
        chk("b2b_spacing", 32'(s2 - s1), 32'(DW + 3));

        // Reset mid-frame abandons the frame silently.
        strobe(1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1, 1'b1);
        chk("pre_rst_busy", 32'({busy_e, busy_o}), 32'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'({busy_e, busy_o}), 0);
        chk("mid_rst_dout", 32'(dout_e), 0);
        chk_quiet("mid_rst");
        repeat (3) begin
            @(posedge clk); #1;
            chk_quiet("post_rst");
        end
        send_frame(8'h55, 1'b0, 1'b1, 1, s1);

        // Random frames; mostly good stop bits, random parity, random strobe spacing.
        for (int n = 0; n < 24; n++) begin
            d = DW'($urandom);
            send_frame(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                       int'($urandom_range(1, 3)), s1);
            if ($urandom_range(0, 1) == 1) begin
                strobe(1'b1, 1, 1'b0);
                chk_quiet("rand_idle");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
